// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, FSM state type and blanking helper for the display scan
package seg_pkg;

  localparam int NDIG  = 4;
  localparam int POS_W = 2;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Position p is a leading zero when it and every more-significant digit
  // (including their decimal points) are zero; the rightmost digit always shows.
  function automatic logic lzb_calc(
    input logic [NDIG*BCD_W-1:0] digs,
    input logic [NDIG-1:0]       dps,
    input logic [POS_W-1:0]      p,
    input logic                  lzb_en
  );
    logic all_zero;
    all_zero = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (k >= int'(p)) begin
        if ((digs[k*BCD_W +: BCD_W] != '0) || dps[k]) begin
          all_zero = 1'b0;
        end
      end
    end
    return lzb_en && (p != '0) && all_zero;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit 7-segment scan controller with gap blanking, LZB and shadow load
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        lzb_en,
  input  logic        load,
  output logic        load_ack,
  output logic [1:0]  pos,
  output logic [3:0]  bcd,
  output logic        dp,
  output logic        blank,
  output logic        frame_start
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLK_DIV - BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_CYC - 1);

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [POS_W-1:0]        pos_n;
  logic                    fs_n;

  logic [NDIG*BCD_W-1:0]   stage_dig, stage_dig_n;
  logic [NDIG-1:0]         stage_dp, stage_dp_n;
  logic                    pending, pending_n;
  logic [NDIG*BCD_W-1:0]   shadow_dig, shadow_dig_n;
  logic [NDIG-1:0]         shadow_dp, shadow_dp_n;
  logic                    apply_edge;
  logic                    ack_n;

  logic [BCD_W-1:0]        bcd_n;
  logic                    dp_n;
  logic                    blank_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pos_n   = pos;
    fs_n    = 1'b0;

    case (state)
      IDLE: begin
        if (en) begin
          state_n = SHOW;
          cnt_n   = '0;
          pos_n   = '0;
          fs_n    = 1'b1;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
          pos_n   = pos + 2'd1;
          fs_n    = (pos == 2'd3);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        pos_n   = '0;
      end
    endcase

    // Disabling abandons the slot immediately rather than finishing it.
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      pos_n   = '0;
      fs_n    = 1'b0;
    end
  end

  // Shadow updates only at a frame boundary so one frame never mixes old and new digits.
  assign apply_edge = (state == IDLE) ||
                      ((state == GAP) && en && (cnt == GAP_LAST) && (pos == 2'd3));

  always_comb begin
    stage_dig_n  = stage_dig;
    stage_dp_n   = stage_dp;
    pending_n    = pending;
    shadow_dig_n = shadow_dig;
    shadow_dp_n  = shadow_dp;
    ack_n        = 1'b0;

    if (load) begin
      stage_dig_n = digits_in;
      stage_dp_n  = dp_in;
      pending_n   = 1'b1;
    end

    if (apply_edge && (load || pending)) begin
      if (load) begin
        shadow_dig_n = digits_in;
        shadow_dp_n  = dp_in;
      end else begin
        shadow_dig_n = stage_dig;
        shadow_dp_n  = stage_dp;
      end
      pending_n = 1'b0;
      ack_n     = 1'b1;
    end
  end

  // Outputs are derived from next-cycle state so they are all registered together.
  always_comb begin
    bcd_n   = shadow_dig_n[{pos_n, 2'b00} +: BCD_W];
    dp_n    = shadow_dp_n[pos_n];
    blank_n = (state_n != SHOW) || lzb_calc(shadow_dig_n, shadow_dp_n, pos_n, lzb_en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pos         <= '0;
      bcd         <= '0;
      dp          <= 1'b0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
      stage_dig   <= '0;
      stage_dp    <= '0;
      pending     <= 1'b0;
      shadow_dig  <= '0;
      shadow_dp   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pos         <= pos_n;
      bcd         <= bcd_n;
      dp          <= dp_n;
      blank       <= blank_n;
      frame_start <= fs_n;
      load_ack    <= ack_n;
      stage_dig   <= stage_dig_n;
      stage_dp    <= stage_dp_n;
      pending     <= pending_n;
      shadow_dig  <= shadow_dig_n;
      shadow_dp   <= shadow_dp_n;
    end
  end

endmodule
